// File: rtl/axi4l_regfile.sv
// rtl/axi4l_regfile.sv - AXI4-Lite slave register bank with strobed writes and per-register write pulses
// Optional AXI4L_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4l_regfile #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int IW     = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_W);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4L_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_DATA   = 1'b1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [1:0]            w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [0:0]            r_state_q, r_state_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IW-1:0]         w_idx, r_idx;
  logic                  w_in_range, r_in_range;

  wire unused_prot = ^{awprot, arprot};

  assign w_idx      = awaddr_q[OFS +: IW];
  assign w_in_range = (awaddr_q < ADDR_LIMIT);
  assign r_idx      = araddr[OFS +: IW];
  assign r_in_range = (araddr < ADDR_LIMIT);

  // Readies look only at registered state, never at the incoming valids.
  assign awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign arready = (r_state_q == R_IDLE);

  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (wvalid && wready) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        if (w_in_range) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) begin
              regs_d[w_idx][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
          end
          wr_pulse_d[w_idx] = 1'b1;
        end
        bvalid_d  = 1'b1;
        bresp_d   = w_in_range ? RESP_OKAY : RESP_OOR;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Reads sample regs_q directly, so an AR on the commit edge sees the old value.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (r_state_q == R_IDLE) begin
      if (arvalid) begin
        rdata_d   = r_in_range ? regs_q[r_idx] : '0;
        rresp_d   = r_in_range ? RESP_OKAY : RESP_OOR;
        rvalid_d  = 1'b1;
        r_state_d = R_DATA;
      end
    end else begin
      if (rready) begin
        rvalid_d  = 1'b0;
        r_state_d = R_IDLE;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      r_state_q  <= R_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      r_state_q  <= r_state_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi4l_regfile.sv
// tb/tb_axi4l_regfile.sv - directed self-checking bench for axi4l_regfile
`timescale 1ns/1ps
module tb_axi4l_regfile;

  localparam int NR = 16;
  localparam logic [31:0] RV = 32'hA5A5A5A5;
`ifdef AXI4L_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [31:0]   awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [31:0]   araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0] wr_pulse;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model [NR];

  always #5 aclk = ~aclk;

  axi4l_regfile #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(NR), .RESET_VALUE(RV)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] reg_word(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int guard;
    aw_done = 0; w_done = 0; guard = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    while (!(aw_done && w_done) && guard < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick; guard++;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; guard = 0;
    while (!bvalid && guard < 20) begin tick; guard++; end
    resp = bresp;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_timeout addr=%h: bvalid=%b required 1", addr, bvalid);
    end
    tick;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int guard;
    guard = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    while (!arready && guard < 20) begin tick; guard++; end
    tick;
    arvalid = 1'b0; guard = 0;
    while (!rvalid && guard < 20) begin tick; guard++; end
    data = rdata; resp = rresp;
    n_cmp++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_timeout addr=%h: rvalid=%b required 1", addr, rvalid);
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [1:0]  r;
    areset = 1'b1;
    repeat (3) tick;
    areset = 1'b0;
    #1;
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_handshake: aw/w/ar/b/r=%b required 11100",
               {awready, wready, arready, bvalid, rvalid});
    end
    n_cmp++;
    if ({bresp, rresp, rdata, wr_pulse} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: bresp=%b rresp=%b rdata=%h wr_pulse=%h required all 0",
               bresp, rresp, rdata, wr_pulse);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (reg_word(i) !== RV) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h required %h", i, reg_word(i), RV);
      end
    end
    tick;
    do_read(32'h3C, d, r);
    n_cmp++;
    if (d !== RV || r !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_read_3c: rdata=%h rresp=%b required %h 00", d, r, RV);
    end
  endtask

  task automatic test_strobe_write;
    logic [1:0] r;
    do_write(32'h08, 32'h0, 4'hF, r);
    model[2] = 32'h0;
    awaddr = 32'h08; wdata = 32'h12345678; wstrb = 4'b0101;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || wr_pulse !== '0 || reg_word(2) !== 32'h0) begin
      n_fail++;
      $display("FAIL strobe_pre_commit: bvalid=%b wr_pulse=%h reg2=%h required 0 0 0",
               bvalid, wr_pulse, reg_word(2));
    end
    tick;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 16'h0004) begin
      n_fail++;
      $display("FAIL strobe_commit: bvalid=%b bresp=%b wr_pulse=%h required 1 00 0004",
               bvalid, bresp, wr_pulse);
    end
    n_cmp++;
    if (reg_word(2) !== 32'h00340078) begin
      n_fail++;
      $display("FAIL strobe_value: reg2=%h required 00340078", reg_word(2));
    end
    tick;
    bready = 1'b0;
    n_cmp++;
    if (wr_pulse !== '0 || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_pulse_width: wr_pulse=%h bvalid=%b required 0000 0", wr_pulse, bvalid);
    end
    model[2] = 32'h00340078;
  endtask

  task automatic test_w_before_aw;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    tick;
    wvalid = 1'b0;
    n_cmp++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      n_fail++;
      $display("FAIL w_held_ready: wready=%b awready=%b required 0 1", wready, awready);
    end
    tick; tick;
    awaddr = 32'h04; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || reg_word(1) !== RV) begin
      n_fail++;
      $display("FAIL w_first_pre_commit: bvalid=%b reg1=%h required 0 %h", bvalid, reg_word(1), RV);
    end
    tick;
    n_cmp++;
    if (reg_word(1) !== 32'hDEADBEEF || wr_pulse !== 16'h0002) begin
      n_fail++;
      $display("FAIL w_first_commit: reg1=%h wr_pulse=%h required deadbeef 0002",
               reg_word(1), wr_pulse);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wr_pulse !== '0 && i > 0) begin
        n_fail++;
        $display("FAIL bresp_hold cycle %0d: bvalid=%b bresp=%b awready=%b required 1 00 0",
                 i, bvalid, bresp, awready);
      end
      if (i < 4) tick;
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      n_fail++;
      $display("FAIL bresp_release: bvalid=%b awready=%b wready=%b required 0 1 1",
               bvalid, awready, wready);
    end
    model[1] = 32'hDEADBEEF;
  endtask

  task automatic test_collision;
    logic [31:0] d;
    logic [1:0]  r;
    awaddr = 32'h10; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h10; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== RV || rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_old_value: rvalid=%b rdata=%h rresp=%b required 1 %h 00",
               rvalid, rdata, rresp, RV);
    end
    n_cmp++;
    if (bvalid !== 1'b1 || reg_word(4) !== 32'h1) begin
      n_fail++;
      $display("FAIL collision_commit: bvalid=%b reg4=%h required 1 00000001", bvalid, reg_word(4));
    end
    rready = 1'b1; bready = 1'b1;
    tick;
    rready = 1'b0; bready = 1'b0;
    model[4] = 32'h1;
    do_read(32'h10, d, r);
    n_cmp++;
    if (d !== 32'h1 || r !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_reread: rdata=%h rresp=%b required 00000001 00", d, r);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d;
    logic [1:0]  r;
    int          saw_pulse;
    saw_pulse = 0;
    awaddr = 32'h40; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    tick;
    if (wr_pulse !== '0) saw_pulse = 1;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== OOR_RESP) begin
      n_fail++;
      $display("FAIL oor_write_resp: bvalid=%b bresp=%b required 1 %b", bvalid, bresp, OOR_RESP);
    end
    bready = 1'b1;
    tick;
    bready = 1'b0;
    if (wr_pulse !== '0) saw_pulse = 1;
    n_cmp++;
    if (saw_pulse != 0) begin
      n_fail++;
      $display("FAIL oor_write_pulse: wr_pulse seen=%0d required 0", saw_pulse);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (reg_word(i) !== model[i]) begin
        n_fail++;
        $display("FAIL oor_reg%0d: got %h required %h", i, reg_word(i), model[i]);
      end
    end
    do_read(32'h40, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== OOR_RESP) begin
      n_fail++;
      $display("FAIL oor_read: rdata=%h rresp=%b required 00000000 %b", d, r, OOR_RESP);
    end
  endtask

  task automatic test_back_to_back;
    int hs_cyc [3];
    logic [31:0] rd [3];
    int k, cyc, nr;
    bit hs;
    k = 0; cyc = 0;
    awaddr = 32'h18; wdata = 32'h600D0006; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (k < 3 && cyc < 40) begin
      hs = awready && wready;
      tick; cyc++;
      if (hs) begin
        hs_cyc[k] = cyc; k++;
        if (k < 3) begin
          awaddr = 32'h18 + 32'(4 * k);
          wdata  = 32'h600D0006 + 32'(k);
        end else begin
          awvalid = 1'b0; wvalid = 1'b0;
        end
      end
    end
    repeat (3) tick;
    bready = 1'b0;
    n_cmp++;
    if (k != 3 || hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin
      n_fail++;
      $display("FAIL b2b_write_rate: count=%0d spacing=%0d,%0d required 3 3,3",
               k, hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
    end
    for (int i = 0; i < 3; i++) model[6+i] = 32'h600D0006 + 32'(i);
    k = 0; cyc = 0; nr = 0;
    araddr = 32'h18; arvalid = 1'b1; rready = 1'b1;
    while ((k < 3 || nr < 3) && cyc < 40) begin
      hs = arvalid && arready;
      if (rvalid && nr < 3) begin rd[nr] = rdata; nr++; end
      tick; cyc++;
      if (hs) begin
        hs_cyc[k] = cyc; k++;
        if (k < 3) araddr = 32'h18 + 32'(4 * k);
        else arvalid = 1'b0;
      end
    end
    rready = 1'b0;
    n_cmp++;
    if (k != 3 || hs_cyc[1] - hs_cyc[0] != 2 || hs_cyc[2] - hs_cyc[1] != 2) begin
      n_fail++;
      $display("FAIL b2b_read_rate: count=%0d spacing=%0d,%0d required 3 2,2",
               k, hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (nr != 3 || rd[i] !== model[6+i]) begin
        n_fail++;
        $display("FAIL b2b_read_data%0d: got %h (count %0d) required %h", i, rd[i], nr, model[6+i]);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d;
    logic [1:0]  r;
    awaddr = 32'h0C; wdata = 32'h11111111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 32'h04; arvalid = 1'b1;
    bready = 1'b0; rready = 1'b0;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick;
    n_cmp++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_setup: bvalid=%b rvalid=%b required 1 1", bvalid, rvalid);
    end
    #2 areset = 1'b1;
    #1;
    n_cmp++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL midflight_drop: bvalid=%b rvalid=%b wr_pulse=%h required 0 0 0",
               bvalid, rvalid, wr_pulse);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (reg_word(i) !== RV) begin
        n_fail++;
        $display("FAIL midflight_reg%0d: got %h required %h", i, reg_word(i), RV);
      end
      model[i] = RV;
    end
    tick;
    areset = 1'b0;
    awaddr = 32'h24; wdata = 32'h0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    #2 areset = 1'b1;
    tick;
    areset = 1'b0;
    repeat (2) tick;
    n_cmp++;
    if (reg_word(9) !== RV || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_commit: reg9=%h bvalid=%b required %h 0", reg_word(9), bvalid, RV);
    end
    do_write(32'h14, 32'hCAFEF00D, 4'hF, r);
    n_cmp++;
    if (r !== 2'b00 || reg_word(5) !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL post_reset_write: bresp=%b reg5=%h required 00 cafef00d", r, reg_word(5));
    end
    do_read(32'h14, d, r);
    n_cmp++;
    if (d !== 32'hCAFEF00D || r !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_read: rdata=%h rresp=%b required cafef00d 00", d, r);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = RV;
    test_reset;
    test_strobe_write;
    test_w_before_aw;
    test_collision;
    test_out_of_range;
    test_back_to_back;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
